// File: rtl/video_timing_pkg.sv
// Default CEA-861 1280x720p60 raster constants shared by the timing generator
// and the game objects that position themselves against HRES/VRES.
package video_timing_pkg;

  localparam int unsigned POS_W = 12;

  localparam int unsigned HRES  = 1280;
  localparam int unsigned HFP   = 110;
  localparam int unsigned HSYNC = 40;
  localparam int unsigned HBP   = 220;

  localparam int unsigned VRES  = 720;
  localparam int unsigned VFP   = 5;
  localparam int unsigned VSYNC = 5;
  localparam int unsigned VBP   = 20;

  localparam int unsigned HTOTAL = HRES + HFP + HSYNC + HBP;
  localparam int unsigned VTOTAL = VRES + VFP + VSYNC + VBP;

  // Positions are presented as signed POS_W values whose MSB stays 0.
  localparam int unsigned POS_MAX = (1 << (POS_W - 1)) - 1;

  typedef logic signed [POS_W-1:0] pos_t;

  function automatic bit fits_pos(input int unsigned total);
    return total <= POS_MAX;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle: position counters plus sync/de/fsync strobes.
interface video_timing_if;
  import video_timing_pkg::*;

  pos_t hpos;
  pos_t vpos;
  logic hsync;
  logic vsync;
  logic de;
  logic fsync;

  modport master (output hpos, vpos, hsync, vsync, de, fsync);
  modport slave  (input  hpos, vpos, hsync, vsync, de, fsync);
endinterface

// File: rtl/video_timing_gen_wrap_counter.sv
// Modulo-(MAX+1) counter that advances on inc and flags the wrapping step.
module wrap_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign wrap = inc && (value == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered
// sync, data-enable and start-of-blanking fsync decode.
module video_timing_gen #(
  parameter int unsigned HRES   = video_timing_pkg::HRES,
  parameter int unsigned VRES   = video_timing_pkg::VRES,
  parameter int unsigned HFP    = video_timing_pkg::HFP,
  parameter int unsigned HSYNC  = video_timing_pkg::HSYNC,
  parameter int unsigned HBP    = video_timing_pkg::HBP,
  parameter int unsigned VFP    = video_timing_pkg::VFP,
  parameter int unsigned VSYNC  = video_timing_pkg::VSYNC,
  parameter int unsigned VBP    = video_timing_pkg::VBP,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  video_timing_if.master        vid
);
  import video_timing_pkg::*;

  localparam int unsigned HT = HRES + HFP + HSYNC + HBP;
  localparam int unsigned VT = VRES + VFP + VSYNC + VBP;
  localparam int unsigned CW = POS_W - 1;

  if (!fits_pos(HT) || !fits_pos(VT)) begin : g_bad_totals
    $error("video_timing_gen: HTOTAL/VTOTAL must not exceed 2047");
  end

  localparam logic [CW-1:0] H_ACT    = CW'(HRES);
  localparam logic [CW-1:0] HS_START = CW'(HRES + HFP);
  localparam logic [CW-1:0] HS_END   = CW'(HRES + HFP + HSYNC - 1);
  localparam logic [CW-1:0] V_ACT    = CW'(VRES);
  localparam logic [CW-1:0] VS_START = CW'(VRES + VFP);
  localparam logic [CW-1:0] VS_END   = CW'(VRES + VFP + VSYNC - 1);

  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hwrap, vwrap;
  logic          hsync_q, vsync_q, de_q, fsync_q;

  wrap_counter #(.MAX(HT - 1), .W(CW)) u_hcnt (
    .clk   (pixel_clk),
    .rst   (rst),
    .inc   (1'b1),
    .value (hcnt),
    .wrap  (hwrap)
  );

  wrap_counter #(.MAX(VT - 1), .W(CW)) u_vcnt (
    .clk   (pixel_clk),
    .rst   (rst),
    .inc   (hwrap),
    .value (vcnt),
    .wrap  (vwrap)
  );

  // Decode is taken from the counters' next values so the registered
  // strobes line up with the registered position on the same cycle.
  always_comb begin
    h_nxt = hwrap ? '0 : hcnt + 1'b1;
    v_nxt = vcnt;
    if (vwrap) begin
      v_nxt = '0;
    end else if (hwrap) begin
      v_nxt = vcnt + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b1;
      fsync_q <= 1'b0;
    end else begin
      hsync_q <= ((h_nxt >= HS_START) && (h_nxt <= HS_END)) ^ ~HS_POL;
      vsync_q <= ((v_nxt >= VS_START) && (v_nxt <= VS_END)) ^ ~VS_POL;
      de_q    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      fsync_q <= (h_nxt == '0) && (v_nxt == V_ACT);
    end
  end

  assign vid.hpos  = $signed({1'b0, hcnt});
  assign vid.vpos  = $signed({1'b0, vcnt});
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.de    = de_q;
  assign vid.fsync = fsync_q;

endmodule
